collatz_sweep: RTL and testbench



---
 rtl/collatz_sweep_pkg.sv | 22 ++
 rtl/collatz_best_reg.sv | 31 +++
 rtl/collatz_sweep.sv | 147 ++++++++++++++
 tb/tb_collatz_sweep.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_sweep_pkg.sv
// Shared types and widths for the Collatz sweep initiator and its stopping-time device.
package collatz_sweep_pkg;

    localparam int unsigned NW = 8;   // operand width n_0
    localparam int unsigned KW = 8;   // stopping-time result width k
    localparam int unsigned CW = 9;   // evaluated-value counter width (0..255)

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAITRDY = 3'd1,
        S_REQ     = 3'd2,
        S_ACK     = 3'd3,
        S_EVAL    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // n = 0 never terminates, so the sweep always starts at 1 or above.
    function automatic logic [NW-1:0] clamp_lo(input logic [NW-1:0] n);
        return (n == '0) ? NW'(1) : n;
    endfunction

endpackage

// File: rtl/collatz_best_reg.sv
// Running maximum of k over the sweep, with the n that produced it and a value counter.
module collatz_best_reg
    import collatz_sweep_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load_en,
    input  logic [NW-1:0] n,
    input  logic [KW-1:0] k,
    output logic [NW-1:0] best_n,
    output logic [KW-1:0] best_k,
    output logic [CW-1:0] count
);

    // First value always wins; afterwards only a strictly larger k replaces, so ties keep the smaller n.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            best_n <= '0;
            best_k <= '0;
            count  <= '0;
        end else if (load_en) begin
            count <= count + CW'(1);
            if ((count == '0) || (k > best_k)) begin
                best_k <= k;
                best_n <= n;
            end
        end
    end

endmodule

// File: rtl/collatz_sweep.sv
// Sweeps n_0 over [n_first, n_last], running one soc/eoc four-phase transaction per value.
module collatz_sweep
    import collatz_sweep_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TW      = 10
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] n_first,
    input  logic [NW-1:0] n_last,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] best_n,
    output logic [KW-1:0] best_k,
    output logic [CW-1:0] count,
    output logic          soc,
    output logic [NW-1:0] n_0,
    input  logic          eoc,
    input  logic [KW-1:0] k
);

    state_t        state;
    logic [NW-1:0] hi;
    logic [KW-1:0] k_q;
    logic [TW-1:0] tmo_cnt;

    logic          start_c;
    logic          load_en_c;
    logic          tmo_hit_c;
    logic [NW-1:0] lo_c;

    // Start is honoured only while idle or finished; timeout fires as the counter reaches TIMEOUT.
    always_comb begin
        start_c   = start && ((state == S_IDLE) || (state == S_DONE));
        load_en_c = (state == S_EVAL);
        tmo_hit_c = (tmo_cnt == TW'(TIMEOUT - 1));
        lo_c      = clamp_lo(n_first);
    end

    // Sweep controller: owns soc/n_0, the range end and the per-phase timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            soc     <= 1'b0;
            n_0     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            hi      <= '0;
            k_q     <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        hi      <= n_last;
                        err     <= 1'b0;
                        tmo_cnt <= '0;
                        if (lo_c > n_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            done  <= 1'b0;
                            n_0   <= lo_c;
                            state <= S_WAITRDY;
                        end
                    end
                end
                S_WAITRDY: begin
                    if (eoc) begin
                        soc     <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_REQ;
                    end else if (tmo_hit_c) begin
                        soc     <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_REQ: begin
                    if (!eoc) begin
                        soc     <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_ACK;
                    end else if (tmo_hit_c) begin
                        soc     <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_ACK: begin
                    if (eoc) begin
                        k_q     <= k;
                        tmo_cnt <= '0;
                        state   <= S_EVAL;
                    end else if (tmo_hit_c) begin
                        soc     <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_EVAL: begin
                    // Equality test before increment, so hi = 255 ends without wrapping.
                    tmo_cnt <= '0;
                    if (n_0 == hi) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n_0   <= n_0 + NW'(1);
                        state <= S_WAITRDY;
                    end
                end
                default: begin
                    soc   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    collatz_best_reg u_best (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_c),
        .load_en (load_en_c),
        .n       (n_0),
        .k       (k_q),
        .best_n  (best_n),
        .best_k  (best_k),
        .count   (count)
    );

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: behavioural stopping-time device, sweep reference model, per-cycle monitor.
module tb_collatz_sweep;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] n_first, n_last;
    logic       done, err;
    logic [7:0] best_n, best_k;
    logic [8:0] count;
    logic       soc;
    logic [7:0] n_0;
    logic       eoc;
    logic [7:0] k;

    always #5 clock = ~clock;

    collatz_sweep #(.TIMEOUT(1023), .TW(10)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .n_first (n_first),
        .n_last  (n_last),
        .done    (done),
        .err     (err),
        .best_n  (best_n),
        .best_k  (best_k),
        .count   (count),
        .soc     (soc),
        .n_0     (n_0),
        .eoc     (eoc),
        .k       (k)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Collatz stopping time and the sweep result computed with plain arithmetic.
    function automatic int steps(input int n);
        int x = n;
        int s = 0;
        if (n <= 0) return 0;
        while (x != 1) begin
            x = (x % 2 != 0) ? 3 * x + 1 : x / 2;
            s++;
        end
        return s;
    endfunction

    typedef struct { int bn; int bk; int cnt; } res_t;

    function automatic res_t ref_sweep(input int f, input int l, input bit constk);
        res_t r;
        int   lo;
        int   kk;
        r  = '{0, 0, 0};
        lo = (f < 1) ? 1 : f;
        for (int n = lo; n <= l; n++) begin
            kk = constk ? 5 : steps(n);
            if (r.cnt == 0 || kk > r.bk) begin
                r.bk = kk;
                r.bn = n;
            end
            r.cnt++;
        end
        return r;
    endfunction

    // Device model: mode 0 = real unit, 1 = constant k=5, 2 = never answers soc.
    int         dev_mode    = 0;
    int         dev_ack_dly = 0;
    int         dev_cmp_min = 0;
    int         dev_cmp_max = 3;
    logic [7:0] dev_cap;
    bit         dev_moved, dev_rst;
    int         dev_w;

    initial begin
        eoc = 1'b1;
        k   = 8'd0;
        forever begin
            @(posedge clock); #1;
            if (dev_mode != 2 && soc === 1'b1 && eoc === 1'b1) begin
                dev_cap   = n_0;
                dev_moved = 1'b0;
                dev_rst   = 1'b0;
                repeat (dev_ack_dly) begin @(posedge clock); #1; end
                if (soc === 1'b1) begin
                    eoc   = 1'b0;
                    dev_w = 0;
                    while (soc === 1'b1 && dev_w < 5000) begin
                        @(posedge clock); #1;
                        dev_w++;
                        if (reset) dev_rst = 1'b1;
                        if (n_0 != dev_cap) dev_moved = 1'b1;
                    end
                    repeat ($urandom_range(dev_cmp_max, dev_cmp_min)) begin
                        @(posedge clock); #1;
                        if (reset) dev_rst = 1'b1;
                        if (n_0 != dev_cap) dev_moved = 1'b1;
                    end
                    k   = (dev_mode == 1) ? 8'd5 : 8'(steps(int'(dev_cap)));
                    eoc = 1'b1;
                    if (!dev_rst) chk("n0_stable", longint'(dev_moved), 0);
                end
            end
        end
    end

    // Expected sweep result, checked by the monitor once the sweep reports done.
    int   exp_bn, exp_bk, exp_cnt, exp_err;
    bit   pending = 1'b0;
    int   soc_rises = 0;
    int   run = 0;
    int   last_run = 0;
    logic prev_soc = 1'b0;
    logic prev_eoc = 1'b1;

    // Monitor: soc may rise only when eoc was 1; tracks soc-high run length; checks finished sweeps.
    always @(negedge clock) begin
        if (soc === 1'b1 && prev_soc !== 1'b1) begin
            soc_rises++;
            chk("soc_rise_with_eoc", longint'(prev_eoc), 1);
        end
        if (soc === 1'b1) run++;
        else begin
            if (prev_soc === 1'b1) last_run = run;
            run = 0;
        end
        if (pending && done === 1'b1) begin
            pending = 1'b0;
            chk("best_n", best_n, exp_bn);
            chk("best_k", best_k, exp_bk);
            chk("count",  count,  exp_cnt);
            chk("err",    err,    exp_err);
        end
        prev_soc = soc;
        prev_eoc = eoc;
    end

    task automatic run_sweep(input int f, input int l, input bit constk, input bit tmo);
        res_t r;
        int   r0;
        int   c;
        r = ref_sweep(f, l, constk);
        if (tmo) begin
            exp_bn = 0; exp_bk = 0; exp_cnt = 0; exp_err = 1;
        end else begin
            exp_bn = r.bn; exp_bk = r.bk; exp_cnt = r.cnt; exp_err = 0;
        end
        r0 = soc_rises;
        @(negedge clock);
        n_first = 8'(f);
        n_last  = 8'(l);
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        pending = 1'b1;
        c = 0;
        while (pending && c < 20000) begin
            @(negedge clock);
            c++;
        end
        chk("sweep_finished", longint'(pending), 0);
        pending = 1'b0;
        if (!tmo) chk("soc_pulses", soc_rises - r0, exp_cnt);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l, c;
        reset   = 1'b1;
        start   = 1'b0;
        n_first = 8'd0;
        n_last  = 8'd0;
        repeat (3) @(negedge clock);
        chk("rst_soc", soc, 0);
        chk("rst_n0", n_0, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_best_n", best_n, 0);
        chk("rst_best_k", best_k, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Hand-computed pins of the directed cases.
        run_sweep(6, 7, 1'b0, 1'b0);
        chk("r6_7_done", done, 1);
        chk("r6_7_best_n", best_n, 7);
        chk("r6_7_best_k", best_k, 16);
        chk("r6_7_count", count, 2);
        run_sweep(1, 10, 1'b0, 1'b0);
        chk("r1_10_best_n", best_n, 9);
        chk("r1_10_best_k", best_k, 19);
        chk("r1_10_count", count, 10);
        run_sweep(1, 1, 1'b0, 1'b0);
        chk("r1_1_best_n", best_n, 1);
        chk("r1_1_best_k", best_k, 0);
        chk("r1_1_count", count, 1);
        run_sweep(0, 0, 1'b0, 1'b0);
        chk("r0_0_done", done, 1);
        chk("r0_0_count", count, 0);
        run_sweep(20, 10, 1'b0, 1'b0);
        chk("r20_10_count", count, 0);
        run_sweep(250, 255, 1'b0, 1'b0);
        chk("r250_255_count", count, 6);
        chk("r250_255_no_wrap", n_0, 255);
        run_sweep(27, 27, 1'b0, 1'b0);
        chk("r27_best_k", best_k, 111);

        dev_mode = 1;
        run_sweep(3, 6, 1'b1, 1'b0);
        chk("tie_best_n", best_n, 3);
        chk("tie_best_k", best_k, 5);
        dev_mode = 0;

        // Randomized ranges and device timing against the reference model.
        for (int i = 0; i < 20; i++) begin
            f = $urandom_range(255, 0);
            l = f + $urandom_range(12, 0);
            if (l > 255) l = 255;
            if ($urandom_range(5, 0) == 0) l = f - 1;
            if (l < 0) l = 0;
            dev_ack_dly = $urandom_range(2, 0);
            dev_cmp_max = $urandom_range(4, 0);
            run_sweep(f, l, 1'b0, 1'b0);
        end
        dev_ack_dly = 0;
        dev_cmp_max = 3;

        // Device never acknowledges: soc high for TIMEOUT cycles, then abort with err.
        dev_mode = 2;
        run_sweep(40, 45, 1'b0, 1'b1);
        chk("tmo_soc_high_cycles", last_run, 1023);
        chk("tmo_soc_low", soc, 0);
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        dev_mode = 0;
        run_sweep(5, 8, 1'b0, 1'b0);
        chk("after_tmo_err_clear", err, 0);

        // Reset while soc is high drops soc on that edge.
        dev_ack_dly = 30;
        @(negedge clock);
        n_first = 8'd5; n_last = 8'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 0;
        while (soc !== 1'b1 && c < 100) begin @(negedge clock); c++; end
        chk("req_reached", soc, 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_req_soc", soc, 0);
        chk("rst_req_n0", n_0, 0);
        chk("rst_req_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        dev_ack_dly = 0;
        repeat (40) @(negedge clock);
        chk("rst_req_eoc_idle", eoc, 1);

        // Reset while the device is busy: no new soc until eoc returns.
        dev_cmp_min = 60;
        dev_cmp_max = 60;
        @(negedge clock);
        n_first = 8'd5; n_last = 8'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 0;
        while (!(soc === 1'b0 && eoc === 1'b0) && c < 100) begin @(negedge clock); c++; end
        chk("ack_reached", eoc, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_ack_soc", soc, 0);
        @(negedge clock);
        reset = 1'b0;
        dev_cmp_min = 0;
        dev_cmp_max = 3;
        run_sweep(5, 6, 1'b0, 1'b0);
        chk("after_rst_best_n", best_n, 6);
        chk("after_rst_best_k", best_k, 8);

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
